// File: rtl/serial_add_acc.sv
// serial_add_acc: bit-serial adder/subtractor with a registered running carry.
// Operand bits arrive LSB first. The assembled word leaves together with
// carry-out and signed overflow.
//
// Handshake semantics, applied to both sides:
// - A transfer happens on a rising clk edge where valid & ready are both high.
// - A producer holds valid and its data stable until the transfer happens.
// - ready never depends on valid. in_ready depends only on the state register.
module serial_add_acc #(
    parameter int WIDTH  = 8,
    parameter bit SUB_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             b_eff;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] shift_next;

    // One full-adder cell on the current bit pair. Subtraction inverts b
    // here; the carry register supplies the +1 seed at the start of each word.
    always_comb begin
        in_ready   = (state_q != HOLD);
        accept     = in_valid & in_ready;
        b_eff      = in_b ^ SUB_EN;
        s_bit      = in_a ^ b_eff ^ carry_q;
        c_next     = (in_a & b_eff) | (in_a & carry_q) | (b_eff & carry_q);
        shift_next = {s_bit, shift_q[WIDTH-1:1]};
    end

    // Next-state logic. clr has priority over both handshakes.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        carry_d     = carry_q;
        shift_d     = shift_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        if (clr) begin
            state_d     = IDLE;
            count_d     = '0;
            carry_d     = SUB_EN;
            shift_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, RUN: begin
                    if (accept) begin
                        shift_d = shift_next;
                        if (count_q == LAST) begin
                            // The last bit completes the word. Overflow is the
                            // carry into the MSB XOR the carry out of the MSB.
                            sum_d       = shift_next;
                            cout_d      = c_next;
                            ovf_d       = carry_q ^ c_next;
                            out_valid_d = 1'b1;
                            state_d     = HOLD;
                            count_d     = '0;
                            carry_d     = SUB_EN;
                        end else begin
                            count_d = count_q + CW'(1);
                            carry_d = c_next;
                            state_d = RUN;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers. Reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            carry_q     <= SUB_EN;
            shift_q     <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            shift_q     <= shift_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Output drive from the registers.
    always_comb begin
        out_valid = out_valid_q;
        out_sum   = sum_q;
        out_cout  = cout_q;
        out_ovf   = ovf_q;
        busy      = (count_q != '0) | out_valid_q;
    end

endmodule

// File: tb/tb_serial_add_acc.sv
// tb_serial_add_acc: directed bench for serial_add_acc.
// One adder instance and one subtractor instance share the clock and reset.
module tb_serial_add_acc;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       out_ready;

    logic       add_in_valid, add_in_ready, add_in_a, add_in_b;
    logic       add_out_valid, add_out_cout, add_out_ovf, add_busy;
    logic [7:0] add_out_sum;

    logic       sub_in_valid, sub_in_ready, sub_in_a, sub_in_b;
    logic       sub_out_valid, sub_out_cout, sub_out_ovf, sub_busy;
    logic [7:0] sub_out_sum;

    int         total;
    int         bad;
    logic [9:0] exp_q[$];

    serial_add_acc #(.WIDTH(8), .SUB_EN(1'b0)) dut_add (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(add_in_valid), .in_ready(add_in_ready),
        .in_a(add_in_a), .in_b(add_in_b),
        .out_valid(add_out_valid), .out_ready(out_ready),
        .out_sum(add_out_sum), .out_cout(add_out_cout),
        .out_ovf(add_out_ovf), .busy(add_busy)
    );

    serial_add_acc #(.WIDTH(8), .SUB_EN(1'b1)) dut_sub (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(sub_in_valid), .in_ready(sub_in_ready),
        .in_a(sub_in_a), .in_b(sub_in_b),
        .out_valid(sub_out_valid), .out_ready(out_ready),
        .out_sum(sub_out_sum), .out_cout(sub_out_cout),
        .out_ovf(sub_out_ovf), .busy(sub_busy)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one bit pair and waits, with a bound, until it is accepted.
    task automatic send_bit(input bit sel, input logic a, input logic b);
        int guard;
        guard = 0;
        if (sel) begin
            sub_in_valid = 1'b1; sub_in_a = a; sub_in_b = b;
        end else begin
            add_in_valid = 1'b1; add_in_a = a; add_in_b = b;
        end
        while (!(sel ? sub_in_ready : add_in_ready) && guard < 40) begin
            tick();
            guard++;
        end
        if (guard >= 40) chk("in_ready_timeout", 32'd0, 32'd1);
        tick();
        add_in_valid = 1'b0;
        sub_in_valid = 1'b0;
    endtask

    // Streams an 8-bit operand pair, LSB first, with optional idle cycles.
    task automatic send_word(input bit sel, input logic [7:0] a, input logic [7:0] b,
                             input bit bubbles);
        for (int i = 0; i < 8; i++) begin
            if (bubbles && ($urandom_range(0, 1) == 1)) begin
                repeat ($urandom_range(1, 2)) begin
                    tick();
                    if (i > 0) chk("busy_bubble", 32'(sel ? sub_busy : add_busy), 32'd1);
                end
            end
            send_bit(sel, a[i], b[i]);
            if (i < 7) chk("busy_run", 32'(sel ? sub_busy : add_busy), 32'd1);
        end
    endtask

    // Scoreboard: compares the held result against the oldest expected entry.
    task automatic check_result(input bit sel);
        int         guard;
        logic [9:0] exp;
        guard = 0;
        while (!(sel ? sub_out_valid : add_out_valid) && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) chk("out_valid_timeout", 32'd0, 32'd1);
        if (exp_q.size() == 0) begin
            chk("exp_q_underflow", 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            chk("out_sum",  32'(sel ? sub_out_sum  : add_out_sum),  32'(exp[7:0]));
            chk("out_cout", 32'(sel ? sub_out_cout : add_out_cout), 32'(exp[8]));
            chk("out_ovf",  32'(sel ? sub_out_ovf  : add_out_ovf),  32'(exp[9]));
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        clr          = 1'b0;
        out_ready    = 1'b1;
        add_in_valid = 1'b0; add_in_a = 1'b0; add_in_b = 1'b0;
        sub_in_valid = 1'b0; sub_in_a = 1'b0; sub_in_b = 1'b0;

        // Reset state.
        #2;
        chk("rst_out_valid", 32'(add_out_valid), 32'd0);
        chk("rst_in_ready",  32'(add_in_ready),  32'd1);
        chk("rst_busy",      32'(add_busy),      32'd0);
        chk("rst_out_sum",   32'(add_out_sum),   32'd0);
        chk("rst_cout",      32'(add_out_cout),  32'd0);
        chk("rst_ovf",       32'(add_out_ovf),   32'd0);
        #10 rst_n = 1'b1;
        tick();

        // 0x5A + 0x3C, back-to-back bits: result appears one cycle after the 8th accept.
        exp_q.push_back({1'b1, 1'b0, 8'h96});
        send_word(1'b0, 8'h5A, 8'h3C, 1'b0);
        chk("lat_out_valid", 32'(add_out_valid), 32'd1);
        chk("lat_in_ready",  32'(add_in_ready),  32'd0);
        check_result(1'b0);
        tick();
        chk("handoff_valid", 32'(add_out_valid), 32'd0);
        chk("handoff_ready", 32'(add_in_ready),  32'd1);
        chk("handoff_busy",  32'(add_busy),      32'd0);

        // 0xFF + 0x01 wraps to zero with carry out.
        exp_q.push_back({1'b0, 1'b1, 8'h00});
        send_word(1'b0, 8'hFF, 8'h01, 1'b0);
        check_result(1'b0);
        tick();

        // 0x7F + 0x01 overflows; the consumer stalls for 5 cycles.
        out_ready = 1'b0;
        exp_q.push_back({1'b1, 1'b0, 8'h80});
        send_word(1'b0, 8'h7F, 8'h01, 1'b0);
        check_result(1'b0);
        for (int k = 0; k < 5; k++) begin
            add_in_valid = 1'b1; add_in_a = 1'b1; add_in_b = 1'b1;
            tick();
            chk("stall_valid", 32'(add_out_valid), 32'd1);
            chk("stall_sum",   32'(add_out_sum),   32'h80);
            chk("stall_cout",  32'(add_out_cout),  32'd0);
            chk("stall_ready", 32'(add_in_ready),  32'd0);
        end
        add_in_valid = 1'b0;
        out_ready    = 1'b1;
        tick();
        chk("release_valid", 32'(add_out_valid), 32'd0);
        chk("release_ready", 32'(add_in_ready),  32'd1);
        chk("release_sum",   32'(add_out_sum),   32'h80);
        exp_q.push_back({1'b0, 1'b0, 8'h02});
        send_word(1'b0, 8'h01, 8'h01, 1'b0);
        check_result(1'b0);
        tick();

        // Subtractor: borrow case, then no-borrow case.
        exp_q.push_back({1'b0, 1'b0, 8'hF0});
        send_word(1'b1, 8'h10, 8'h20, 1'b0);
        check_result(1'b1);
        tick();
        exp_q.push_back({1'b0, 1'b1, 8'h10});
        send_word(1'b1, 8'h20, 8'h10, 1'b0);
        check_result(1'b1);
        tick();

        // Idle cycles inside the word do not change the result.
        exp_q.push_back({1'b1, 1'b0, 8'h96});
        send_word(1'b0, 8'h5A, 8'h3C, 1'b1);
        check_result(1'b0);
        chk("bubble_busy_hold", 32'(add_busy), 32'd1);
        tick();
        chk("bubble_busy_done", 32'(add_busy), 32'd0);

        // clr after three bits. The bit presented with clr is dropped.
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1, 1'b1);
        chk("pre_clr_busy", 32'(add_busy), 32'd1);
        clr = 1'b1; add_in_valid = 1'b1; add_in_a = 1'b1; add_in_b = 1'b1;
        tick();
        clr = 1'b0; add_in_valid = 1'b0;
        chk("clr_busy",  32'(add_busy),      32'd0);
        chk("clr_ready", 32'(add_in_ready),  32'd1);
        chk("clr_valid", 32'(add_out_valid), 32'd0);
        chk("clr_sum",   32'(add_out_sum),   32'h96);
        exp_q.push_back({1'b0, 1'b0, 8'h07});
        send_word(1'b0, 8'h03, 8'h04, 1'b0);
        check_result(1'b0);
        tick();

        // Asynchronous reset mid-word, asserted and released between clock edges.
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(add_out_valid), 32'd0);
        chk("arst_ready", 32'(add_in_ready),  32'd1);
        chk("arst_busy",  32'(add_busy),      32'd0);
        chk("arst_sum",   32'(add_out_sum),   32'd0);
        chk("arst_cout",  32'(add_out_cout),  32'd0);
        chk("arst_ovf",   32'(add_out_ovf),   32'd0);
        #2 rst_n = 1'b1;
        tick();
        exp_q.push_back({1'b1, 1'b0, 8'h96});
        send_word(1'b0, 8'h5A, 8'h3C, 1'b0);
        check_result(1'b0);
        tick();

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
